// File: rtl/fnd_scan_controller.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Latches value/dp/blank words and swaps them in only at frame boundaries.
module fnd_scan_controller #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 100000,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int HEX_EN           = 1,
  parameter int LZB_EN           = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  output logic [7:0]                o_font,
  output logic [NUM_DIGITS-1:0]     o_digit,
  output logic                      o_frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      w_step;
  logic                      w_frame_end;

  logic [4*NUM_DIGITS-1:0]   r_pend_value;
  logic [NUM_DIGITS-1:0]     r_pend_dp;
  logic [NUM_DIGITS-1:0]     r_pend_blank;
  logic                      r_pend_valid;
  logic [4*NUM_DIGITS-1:0]   r_act_value;
  logic [NUM_DIGITS-1:0]     r_act_dp;
  logic [NUM_DIGITS-1:0]     r_act_blank;

  logic [NUM_DIGITS-1:0]     w_zero_up;
  logic [NUM_DIGITS-1:0]     w_sel;
  logic [7:0]                w_font [NUM_DIGITS];
  logic [7:0]                w_font_next;
  logic [NUM_DIGITS-1:0]     w_digit_next;

  logic [7:0]                r_font;
  logic [NUM_DIGITS-1:0]     r_digit;
  logic                      r_frame_tick;
  logic                      r_wrap;

  // Segment pattern {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = (HEX_EN != 0) ? 7'h08 : 7'h7F;
      4'hB: seg = (HEX_EN != 0) ? 7'h03 : 7'h7F;
      4'hC: seg = (HEX_EN != 0) ? 7'h46 : 7'h7F;
      4'hD: seg = (HEX_EN != 0) ? 7'h21 : 7'h7F;
      4'hE: seg = (HEX_EN != 0) ? 7'h06 : 7'h7F;
      default: seg = (HEX_EN != 0) ? 7'h0E : 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_step      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_step && (r_idx == IDX_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_step) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Active regs only change on the frame_end edge, so a frame is never torn.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
    end else if (i_load && w_frame_end) begin
      r_act_value  <= i_value;
      r_act_dp     <= i_dp;
      r_act_blank  <= i_blank;
      r_pend_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_pend_value <= i_value;
        r_pend_dp    <= i_dp;
        r_pend_blank <= i_blank;
        r_pend_valid <= 1'b1;
      end
      if (w_frame_end && r_pend_valid) begin
        r_act_value  <= r_pend_value;
        r_act_dp     <= r_pend_dp;
        r_act_blank  <= r_pend_blank;
        r_pend_valid <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [6:0] w_seg;
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_zero_up[gi] = (r_act_value[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign w_zero_up[gi] = (r_act_value[4*gi +: 4] == 4'd0) && w_zero_up[gi+1];
      end
      // Digit 0 always shows its glyph so a zero value still reads "0".
      if (gi == 0 || LZB_EN == 0) begin : g_nolzb
        assign w_seg = f_glyph(r_act_value[4*gi +: 4]);
      end else begin : g_lzb
        assign w_seg = w_zero_up[gi] ? 7'h7F : f_glyph(r_act_value[4*gi +: 4]);
      end
      assign w_font[gi] = r_act_blank[gi] ? 8'hFF : {~r_act_dp[gi], w_seg};
      assign w_sel[gi]  = (r_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    w_font_next = 8'hFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_sel[k]) w_font_next = w_font[k];
    end
    w_digit_next = (DIGIT_ACTIVE_LOW != 0) ? ~w_sel : w_sel;
  end

  // r_wrap marks idx having just wrapped, so the tick lands with digit 0's select.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_font       <= 8'hFF;
      r_digit      <= DIGIT_OFF;
      r_frame_tick <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_font       <= w_font_next;
      r_digit      <= w_digit_next;
      r_frame_tick <= r_wrap;
      r_wrap       <= w_frame_end;
    end
  end

  assign o_font       = r_font;
  assign o_digit      = r_digit;
  assign o_frame_tick = r_frame_tick;

endmodule
